// File: rtl/piso_tx_if.sv
// piso_tx_if: load/ready handshake and serial output bundle of the transmitter
interface piso_tx_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] din;
  logic             load;
  logic             ready;
  logic             out;
  logic             out_valid;
  logic             done;
  modport master (output din, load, input ready, out, out_valid, done);
  modport slave  (input din, load, output ready, out, out_valid, done);
endinterface

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter with gapless back-to-back words
module piso_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic       cl,
  input logic       res,
  piso_tx_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sr;
  logic             w_last, w_ready, w_accept;
  logic [WIDTH-1:0] w_shifted;
  assign w_last    = (r_state == SHIFT) && (r_cnt == CW'(WIDTH - 1));
  assign w_ready   = (r_state == IDLE) || w_last;
  assign w_accept  = bus.load && w_ready;
  assign w_shifted = MSB_FIRST ? {r_sr[WIDTH-2:0], 1'b0} : {1'b0, r_sr[WIDTH-1:1]};
  // state register
  always_ff @(posedge cl)
    r_state <= res ? IDLE : w_next;
  // next state: a load accepted in IDLE or on the last bit keeps shifting
  always_comb
    w_next = (w_accept || (r_state == SHIFT && !w_last)) ? SHIFT : IDLE;
  // shift register and bit counter; a new word is captured only when ready
  always_ff @(posedge cl)
    if (res) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_sr  <= bus.din;
      r_cnt <= '0;
    end else if (r_state == SHIFT) begin
      r_sr  <= w_shifted;
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  // outputs: serial line decoded from registered state only, held low when idle
  always_comb begin
    bus.out_valid = (r_state == SHIFT);
    bus.out       = bus.out_valid && (MSB_FIRST ? r_sr[WIDTH-1] : r_sr[0]);
    bus.done      = w_last;
    bus.ready     = w_ready;
  end
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: directed checks of piso_tx in both bit orders
module tb_piso_tx;
  logic cl = 1'b0;
  logic res = 1'b1;
  int   tests = 0;
  int   fails = 0;
  logic [15:0] w;
  piso_tx_if #(.WIDTH(8)) pa ();
  piso_tx_if #(.WIDTH(8)) pb ();
  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (.cl(cl), .res(res), .bus(pa));
  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (.cl(cl), .res(res), .bus(pb));
  always #5 cl = ~cl;
  task automatic tick;
    @(posedge cl);
    @(negedge cl);
  endtask
  task automatic chk(input string t, input int sel, input logic o, input logic ov,
                     input logic d, input logic r);
    logic [3:0] got, exp;
    got = sel ? {pb.out, pb.out_valid, pb.done, pb.ready}
              : {pa.out, pa.out_valid, pa.done, pa.ready};
    exp = {o, ov, d, r};
    tests++;
    assert (got === exp) else begin
      fails++;
      $display("FAIL %s {out,out_valid,done,ready} got=%b exp=%b", t, got, exp);
      $error("check %s", t);
    end
  endtask
  initial begin
    pa.din = '0; pa.load = 0; pb.din = '0; pb.load = 0;
    tick; tick;
    chk("reset_a", 0, 0, 0, 0, 1);
    chk("reset_b", 1, 0, 0, 0, 1);
    res = 0;
    // MSB first A5
    pa.din = 8'hA5; pa.load = 1; tick; pa.load = 0;
    w = 16'h00A5;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("a5_c%0d", k), 0, w[8-k], 1, k == 8, k == 8);
      tick;
    end
    chk("a5_idle", 0, 0, 0, 0, 1);
    // LSB first 01 and 80
    for (int n = 0; n < 2; n++) begin
      w = n ? 16'h0080 : 16'h0001;
      pb.din = w[7:0]; pb.load = 1; tick; pb.load = 0;
      for (int k = 1; k <= 8; k++) begin
        chk($sformatf("lsb%0d_c%0d", n, k), 1, w[k-1], 1, k == 8, k == 8);
        tick;
      end
      chk($sformatf("lsb%0d_idle", n), 1, 0, 0, 0, 1);
    end
    // back-to-back A5 then 3C
    w = 16'hA53C;
    pa.din = 8'hA5; pa.load = 1; tick; pa.load = 0;
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("b2b_c%0d", k), 0, w[16-k], 1, k == 8 || k == 16, k == 8 || k == 16);
      if (k == 8) begin pa.din = 8'h3C; pa.load = 1; end
      tick;
      pa.load = 0;
    end
    chk("b2b_idle", 0, 0, 0, 0, 1);
    // load ignored mid-word
    w = 16'h00A5;
    pa.din = 8'hA5; pa.load = 1; tick; pa.load = 0;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("ign_c%0d", k), 0, w[8-k], 1, k == 8, k == 8);
      if (k == 3) begin pa.din = 8'hFF; pa.load = 1; end
      tick;
      pa.load = 0;
    end
    chk("ign_idle", 0, 0, 0, 0, 1);
    // reset mid-word, then clean 81
    pa.din = 8'hA5; pa.load = 1; tick; pa.load = 0;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("mid_c%0d", k), 0, w[8-k], 1, 0, 0);
      if (k == 4) res = 1;
      tick;
    end
    res = 0;
    chk("mid_reset", 0, 0, 0, 0, 1);
    w = 16'h0081;
    pa.din = 8'h81; pa.load = 1; tick; pa.load = 0;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("x81_c%0d", k), 0, w[8-k], 1, k == 8, k == 8);
      tick;
    end
    chk("x81_idle", 0, 0, 0, 0, 1);
    // reset wins over load
    res = 1; pa.din = 8'hFF; pa.load = 1; pb.din = 8'hFF; pb.load = 1;
    tick;
    res = 0; pa.load = 0; pb.load = 0;
    chk("prio_a", 0, 0, 0, 0, 1);
    chk("prio_b", 1, 0, 0, 0, 1);
    tick;
    chk("prio_a2", 0, 0, 0, 0, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
